// File: rtl/display_scheduler_if.sv
// display_scheduler_if: key/score/timer inputs and scan/page/blank outputs of the display scheduler
//   key_page    raw page key, active-low, asynchronous
//   score_event single-cycle pulse on any score change
//   time_zero   game timer expired level
//   scan_tick   one-cycle digit advance strobe
//   digit_sel   one-hot digit enable, bit0 = rightmost digit
//   page_sel    0 = time page, 1 = score page
//   blank       1 = all segments off
//   mode        00 AUTO, 01 LOCK_TIME, 10 LOCK_SCORE
//   hold_active score hold in progress
interface display_scheduler_if;
  logic       key_page;
  logic       score_event;
  logic       time_zero;
  logic       scan_tick;
  logic [5:0] digit_sel;
  logic       page_sel;
  logic       blank;
  logic [1:0] mode;
  logic       hold_active;
  modport master (output key_page, score_event, time_zero,
                  input scan_tick, digit_sel, page_sel, blank, mode, hold_active);
  modport slave (input key_page, score_event, time_zero,
                 output scan_tick, digit_sel, page_sel, blank, mode, hold_active);
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: scan strobe, digit select, page choice and blink control for a 6-digit scoreboard mux
//   clock  system clock, posedge
//   rst_n  synchronous reset, active-low
//   bus    slave side of display_scheduler_if (key/score/timer in, scan/page/blank/mode/hold out)
module display_scheduler #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE     = 20,
  parameter int ROTATE_TICKS = 3000,
  parameter int HOLD_TICKS   = 2000,
  parameter int BLINK_TICKS  = 250
) (
  input logic                clock,
  input logic                rst_n,
  display_scheduler_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int RW = $clog2(ROTATE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  typedef enum logic [1:0] {AUTO = 2'b00, LOCK_TIME = 2'b01, LOCK_SCORE = 2'b10} mode_t;
  mode_t         mode_q, mode_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [5:0]    dig_q, dig_d;
  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] low_q, low_d;
  logic          armed_q, armed_d;
  logic [RW-1:0] rot_q, rot_d;
  logic          auto_q, auto_d;
  logic          hold_q, hold_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          page_q, page_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ph_q, ph_d;
  logic          blank_q, blank_d;
  logic          key_evt, rot_inc, rot_wrap, req, blink_on, bwrap;
  always_comb begin
    pre_d    = pre_q == PW'(SCAN_DIV - 1) ? '0 : pre_q + PW'(1);
    tick_d   = pre_q == PW'(SCAN_DIV - 1);
    dig_d    = tick_q ? {dig_q[4:0], dig_q[5]} : dig_q;
    sync_d   = {sync_q[0], bus.key_page};
    // sync_q[1] is the synchronized key; one event per press, re-armed by a released sample
    key_evt  = tick_q && !sync_q[1] && armed_q && low_q == DW'(DEBOUNCE - 1);
    low_d    = !tick_q ? low_q : (sync_q[1] || key_evt) ? '0 : armed_q ? low_q + DW'(1) : low_q;
    armed_d  = !tick_q ? armed_q : sync_q[1] ? 1'b1 : armed_q && !key_evt;
    rot_inc  = mode_q == AUTO && !hold_q && tick_q;
    rot_wrap = rot_inc && rot_q == RW'(ROTATE_TICKS - 1);
    // a mode change restarts rotation on the time page
    rot_d    = (key_evt || rot_wrap) ? '0 : rot_inc ? rot_q + RW'(1) : rot_q;
    auto_d   = key_evt ? 1'b0 : rot_wrap ? ~auto_q : auto_q;
    hcnt_d   = bus.score_event ? HW'(HOLD_TICKS) : (hold_q && tick_q) ? hcnt_q - HW'(1) : hcnt_q;
    hold_d   = bus.score_event || (hold_q && !(tick_q && hcnt_q == HW'(1)));
    req      = hold_q || mode_q == LOCK_SCORE || (mode_q == AUTO && auto_q);
    // page only changes as the scan wraps to the rightmost digit, so no frame mixes pages
    page_d   = (tick_q && dig_q[5]) ? req : page_q;
    blink_on = bus.time_zero && !page_q;
    bwrap    = tick_q && bcnt_q == BW'(BLINK_TICKS - 1);
    bcnt_d   = (!blink_on || bwrap) ? '0 : tick_q ? bcnt_q + BW'(1) : bcnt_q;
    // ph is the phase since blinking started; phase 0 shows blank=1
    ph_d     = blink_on && (ph_q ^ bwrap);
    blank_d  = blink_on && !ph_d;
  end
  always_comb begin
    mode_d = !key_evt ? mode_q : mode_q == AUTO ? LOCK_TIME : mode_q == LOCK_TIME ? LOCK_SCORE : AUTO;
  end
  always_ff @(posedge clock) begin
    if (!rst_n) mode_q <= AUTO;
    else        mode_q <= mode_d;
  end
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      dig_q   <= 6'b000001;
      sync_q  <= 2'b11;
      low_q   <= '0;
      armed_q <= 1'b1;
      rot_q   <= '0;
      auto_q  <= 1'b0;
      hold_q  <= 1'b0;
      hcnt_q  <= '0;
      page_q  <= 1'b0;
      bcnt_q  <= '0;
      ph_q    <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      dig_q   <= dig_d;
      sync_q  <= sync_d;
      low_q   <= low_d;
      armed_q <= armed_d;
      rot_q   <= rot_d;
      auto_q  <= auto_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      page_q  <= page_d;
      bcnt_q  <= bcnt_d;
      ph_q    <= ph_d;
      blank_q <= blank_d;
    end
  end
  assign bus.scan_tick   = tick_q;
  assign bus.digit_sel   = dig_q;
  assign bus.page_sel    = page_q;
  assign bus.blank       = blank_q;
  assign bus.mode        = mode_q;
  assign bus.hold_active = hold_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: scoreboard bench for display_scheduler against a behavioural model
module tb_display_scheduler;
  localparam int SD = 4, DEB = 2, ROT = 12, HOLD = 6, BL = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  display_scheduler_if bus();
  display_scheduler #(.SCAN_DIV(SD), .DEBOUNCE(DEB), .ROTATE_TICKS(ROT), .HOLD_TICKS(HOLD), .BLINK_TICKS(BL))
    dut (.clock(clk), .rst_n(rst_n), .bus(bus));
  int total = 0, bad = 0;
  logic [11:0] exp_q[$];
  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask
  // model state: edge count, tick, digit index, page, blank, mode, hold, remaining hold,
  // rotation ticks, auto page, low samples, armed, synchronizer history, blink ticks/phase
  int n, tk, dig, pg, blk, md, hld, hleft, rot, apg, lows, armed, s1, s2, bt, bph, req, kev, cond;
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      n = 0; tk = 0; dig = 0; pg = 0; blk = 0; md = 0; hld = 0; hleft = 0; rot = 0; apg = 0;
      lows = 0; armed = 1; s1 = 1; s2 = 1; bt = 0; bph = 0;
    end else begin
      req = hld != 0 ? 1 : md == 1 ? 0 : md == 2 ? 1 : apg;
      cond = (bus.time_zero && pg == 0) ? 1 : 0;
      kev = 0;
      if (tk != 0) begin
        if (s2 != 0) begin lows = 0; armed = 1; end
        else if (armed != 0) begin
          lows++;
          if (lows >= DEB) begin kev = 1; armed = 0; lows = 0; end
        end
      end
      if (md == 0 && hld == 0 && tk != 0) begin
        rot++;
        if (rot == ROT) begin rot = 0; apg = 1 - apg; end
      end
      if (kev != 0) begin md = (md + 1) % 3; rot = 0; apg = 0; end
      if (bus.score_event) begin hld = 1; hleft = HOLD; end
      else if (hld != 0 && tk != 0) begin
        hleft--;
        if (hleft == 0) hld = 0;
      end
      if (tk != 0 && dig == 5) pg = req;
      if (cond != 0) begin
        if (tk != 0) begin
          bt++;
          if (bt == BL) begin bt = 0; bph = 1 - bph; end
        end
        blk = 1 - bph;
      end else begin bt = 0; bph = 0; blk = 0; end
      if (tk != 0) dig = (dig + 1) % 6;
      n++;
      tk = (n % SD == 0) ? 1 : 0;
      s2 = s1;
      s1 = bus.key_page ? 1 : 0;
    end
    exp_q.push_back({tk[0], 6'(1 << dig), pg[0], blk[0], md[1:0], hld[0]});
  end
  logic [11:0] e;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scan_tick", int'(bus.scan_tick), int'(e[11]));
      chk("digit_sel", int'(bus.digit_sel), int'(e[10:5]));
      chk("page_sel", int'(bus.page_sel), int'(e[4]));
      chk("blank", int'(bus.blank), int'(e[3]));
      chk("mode", int'(bus.mode), int'(e[2:1]));
      chk("hold_active", int'(bus.hold_active), int'(e[0]));
    end
  end
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask
  task automatic press(input int low_cycles);
    bus.key_page = 1'b0;
    step(low_cycles);
    bus.key_page = 1'b1;
    step(12);
  endtask
  task automatic pulse();
    bus.score_event = 1'b1;
    step(1);
    bus.score_event = 1'b0;
  endtask
  initial begin
    bus.key_page = 1'b1;
    bus.score_event = 1'b0;
    bus.time_zero = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(120);
    bus.key_page = 1'b0;
    step(4);
    bus.key_page = 1'b1;
    step(12);
    chk("mode_single_sample", int'(bus.mode), 0);
    press(12);
    chk("mode_lock_time", int'(bus.mode), 1);
    step(80);
    chk("page_locked_time", int'(bus.page_sel), 0);
    press(12);
    chk("mode_lock_score", int'(bus.mode), 2);
    press(12);
    chk("mode_auto", int'(bus.mode), 0);
    press(12);
    pulse();
    step(60);
    pulse();
    step(12);
    pulse();
    step(40);
    bus.key_page = 1'b0;
    step(7);
    pulse();
    step(8);
    bus.key_page = 1'b1;
    step(40);
    for (int i = 0; i < 3; i++) if (md != 1) press(12);
    bus.time_zero = 1'b1;
    step(60);
    press(12);
    step(40);
    press(12);
    press(12);
    step(40);
    bus.time_zero = 1'b0;
    step(10);
    pulse();
    bus.key_page = 1'b0;
    step(6);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(30);
    bus.key_page = 1'b1;
    step(20);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) bus.key_page = ~bus.key_page;
      bus.score_event = ($urandom_range(39) == 0);
      if ($urandom_range(63) == 0) bus.time_zero = ~bus.time_zero;
      rst_n = ($urandom_range(699) != 0);
      step(1);
    end
    rst_n = 1'b1;
    bus.score_event = 1'b0;
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
